// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer: register offsets, bus modes, CTRL layout, FSM states.
package tick_timer_pkg;

    localparam logic [31:0] OFS_CTRL   = 32'd0;
    localparam logic [31:0] OFS_RELOAD = 32'd4;
    localparam logic [31:0] OFS_COUNT  = 32'd8;
    localparam logic [31:0] OFS_STATUS = 32'd12;
    localparam logic [31:0] OFS_PRESC  = 32'd16;

    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic enable;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tick_timer_divider.sv
// Tick prescaler: passes every (presc+1)-th tick_strobe as a counted tick.
// Latency: combinational pulse in the strobe cycle; clr restarts the count at the next edge.
// Backpressure: none; strobes are never stalled, only thinned.
module tick_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        tick_strobe,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] cnt;

    // >= rather than == so lowering presc mid-count cannot strand the counter above it
    assign tick = tick_strobe && (cnt >= presc);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (tick_strobe) begin
            cnt <= (cnt >= presc) ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// Memory-mapped countdown timer with level irq, fed by the 1 kHz tick strobe; TICK_TIMER_PRESCALE_EN adds PRESC.
// Latency: reads combinational in the mode=01 cycle, writes at the next posedge, irq one cycle behind pending.
// Backpressure: none; every bus access completes in one cycle and ticks are never queued.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4014
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic        tick_strobe,
    output logic        irq
);

    ctrl_t       ctrl;
    ctrl_t       wdat_ctrl;
    state_t      state;
    logic [31:0] reload;
    logic [31:0] count;
    logic        pending;
    logic        rd_en, wr_en;
    logic        sel_ctrl, sel_reload, sel_count, sel_status;
    logic        wr_ctrl, start, counted_tick;
    logic        rd_hit;
    logic [31:0] rd_dat;

    assign rd_en      = (data_bus_mode == MODE_READ);
    assign wr_en      = (data_bus_mode == MODE_WRITE);
    assign sel_ctrl   = (data_bus_addr == BASE_ADDR + OFS_CTRL);
    assign sel_reload = (data_bus_addr == BASE_ADDR + OFS_RELOAD);
    assign sel_count  = (data_bus_addr == BASE_ADDR + OFS_COUNT);
    assign sel_status = (data_bus_addr == BASE_ADDR + OFS_STATUS);
    assign wdat_ctrl  = ctrl_t'(data_bus_data[2:0]);
    assign wr_ctrl    = wr_en && sel_ctrl;
    assign start      = wr_ctrl && wdat_ctrl.enable && (reload != 32'd0);

`ifdef TICK_TIMER_PRESCALE_EN
    logic [15:0] presc;
    logic        sel_presc;

    assign sel_presc = (data_bus_addr == BASE_ADDR + OFS_PRESC);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (wr_en && sel_presc) begin
            presc <= data_bus_data[15:0];
        end
    end

    tick_divider u_tick_divider (
        .clk         (clk),
        .reset       (reset),
        .clr         (start),
        .tick_strobe (tick_strobe),
        .presc       (presc),
        .tick        (counted_tick)
    );
`else
    assign counted_tick = tick_strobe;
`endif

    always_comb begin
        rd_hit = 1'b0;
        rd_dat = '0;
        if (rd_en) begin
            if (sel_ctrl) begin
                rd_hit = 1'b1;
                rd_dat = {29'd0, ctrl};
            end else if (sel_reload) begin
                rd_hit = 1'b1;
                rd_dat = reload;
            end else if (sel_count) begin
                rd_hit = 1'b1;
                rd_dat = count;
            end else if (sel_status) begin
                rd_hit = 1'b1;
                rd_dat = {31'd0, pending};
`ifdef TICK_TIMER_PRESCALE_EN
            end else if (sel_presc) begin
                rd_hit = 1'b1;
                rd_dat = {16'd0, presc};
`endif
            end
        end
    end

    assign data_bus_data = rd_hit ? rd_dat : 'z;

    // Any CTRL write owns the edge, so a coincident tick is dropped.
    // The expiry set comes after the STATUS clear so that set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            reload  <= '0;
            count   <= '0;
            pending <= 1'b0;
            state   <= ST_IDLE;
            irq     <= 1'b0;
        end else begin
            irq <= pending & ctrl.irq_en;
            if (wr_en && sel_reload) begin
                reload <= data_bus_data;
            end
            if (wr_en && sel_status && data_bus_data[0]) begin
                pending <= 1'b0;
            end
            if (wr_ctrl) begin
                ctrl.irq_en   <= wdat_ctrl.irq_en;
                ctrl.periodic <= wdat_ctrl.periodic;
                ctrl.enable   <= start;
                if (start) begin
                    count <= reload;
                    state <= ST_RUN;
                end else if (!wdat_ctrl.enable && state == ST_RUN) begin
                    state <= ST_IDLE;
                end
            end else if (state == ST_RUN && counted_tick) begin
                if (count > 32'd1) begin
                    count <= count - 32'd1;
                end else begin
                    pending <= 1'b1;
                    if (ctrl.periodic) begin
                        count <= reload;
                    end else begin
                        count       <= '0;
                        ctrl.enable <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
            end
        end
    end

endmodule
